ws281x_wave_gen: RTL and testbench



---
 rtl/ws281x_pkg.sv | 19 +
 rtl/ws281x_wave_gen_if.sv | 28 ++
 rtl/ws281x_tick_div.sv | 25 ++
 rtl/ws281x_wave_gen.sv | 121 ++++++++++++
 tb/tb_ws281x_wave_gen.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/ws281x_pkg.sv
// Shared types and default timing constants for the WS281x waveform generator.
package ws281x_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HIGH  = 2'd1,
    LOW   = 2'd2,
    LATCH = 2'd3
  } wave_state_t;

  localparam int CNT_W     = 8;
  // Default code timings in 10 ns units (200 MHz clock, TICK_DIV = 2).
  localparam int T0H       = 1;
  localparam int T0S       = 128;
  localparam int T1H       = 254;
  localparam int T1S       = 255;
  localparam int RST_UNITS = 6000;

endpackage

// File: rtl/ws281x_wave_gen_if.sv
// Bit/latch request channel between the frame controller and the waveform generator.
interface ws281x_wave_gen_if #(
  parameter int CNT_W = ws281x_pkg::CNT_W
);
  // Handshake: a request (bit_vld_i, or rst_req_i with bit_vld_i low) is taken on
  // any clock where bit_rdy_o is high; bit_vld_i wins when both are raised. Data and
  // timing counts are sampled only on that clock. rst_done_o pulses once per latch.
  logic             bit_vld_i;
  logic             bit_data_i;
  logic [CNT_W-1:0] t0h_cnt_i;
  logic [CNT_W-1:0] t0s_cnt_i;
  logic [CNT_W-1:0] t1h_cnt_i;
  logic [CNT_W-1:0] t1s_cnt_i;
  logic             rst_req_i;
  logic             bit_rdy_o;
  logic             rst_done_o;

  modport master (
    output bit_vld_i, bit_data_i, t0h_cnt_i, t0s_cnt_i, t1h_cnt_i, t1s_cnt_i, rst_req_i,
    input  bit_rdy_o, rst_done_o
  );

  modport slave (
    input  bit_vld_i, bit_data_i, t0h_cnt_i, t0s_cnt_i, t1h_cnt_i, t1s_cnt_i, rst_req_i,
    output bit_rdy_o, rst_done_o
  );

endinterface

// File: rtl/ws281x_tick_div.sv
// Timing-unit prescaler: tick_o is high one clock in every DIV; clr_i restarts the phase.
module ws281x_tick_div #(
  parameter int DIV = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  output logic tick_o
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [W-1:0] div_cnt;

  assign tick_o = (div_cnt == W'(DIV - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i || tick_o) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + W'(1);
    end
  end

endmodule

// File: rtl/ws281x_wave_gen.sv
// WS281x data-line waveform generator: timed high/low bit codes plus latch low period.
// Define WS281X_WAVE_INV_EN to invert bit_code_o for an inverting level shifter.
module ws281x_wave_gen #(
  parameter int TICK_DIV  = 2,
  parameter int CNT_W     = ws281x_pkg::CNT_W,
  parameter int RST_UNITS = ws281x_pkg::RST_UNITS,
  parameter int RST_W     = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  ws281x_wave_gen_if.slave        bus,
  output logic                    bit_code_o,
  output ws281x_pkg::wave_state_t state_o
);

  import ws281x_pkg::*;

`ifdef WS281X_WAVE_INV_EN
  localparam logic IDLE_LVL = 1'b1;
`else
  localparam logic IDLE_LVL = 1'b0;
`endif

  wave_state_t      state_q, state_d;
  logic [CNT_W-1:0] unit_q, unit_d, th_q, th_d, ts_q, ts_d;
  logic [RST_W-1:0] rst_cnt_q, rst_cnt_d;
  logic             code_q, done_q, done_d;
  logic             tick, rdy, end_bit, bit_acc, lat_acc;
  logic [CNT_W-1:0] sel_th, sel_ts_raw, sel_ts;
  logic [CNT_W:0]   unit_inc;
  logic [RST_W:0]   rst_inc;

  ws281x_tick_div #(.DIV(TICK_DIV)) u_tick_div (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clr_i  (bit_acc || lat_acc),
    .tick_o (tick)
  );

  assign unit_inc   = {1'b0, unit_q} + (CNT_W + 1)'(1);
  assign rst_inc    = {1'b0, rst_cnt_q} + (RST_W + 1)'(1);
  assign sel_th     = bus.bit_data_i ? bus.t1h_cnt_i : bus.t0h_cnt_i;
  assign sel_ts_raw = bus.bit_data_i ? bus.t1s_cnt_i : bus.t0s_cnt_i;
  // A period shorter than its high time is stretched to cover the high phase.
  assign sel_ts     = (sel_ts_raw < sel_th) ? sel_th : sel_ts_raw;

  // Ready during the last clock of LOW so the next bit starts with no gap.
  assign end_bit = (state_q == LOW) && tick && (unit_inc >= {1'b0, ts_q});
  assign rdy     = (state_q == IDLE) || end_bit;
  assign bit_acc = bus.bit_vld_i && rdy;
  assign lat_acc = bus.rst_req_i && rdy && !bus.bit_vld_i;

  always_comb begin
    state_d   = state_q;
    unit_d    = unit_q;
    th_d      = th_q;
    ts_d      = ts_q;
    rst_cnt_d = rst_cnt_q;
    done_d    = 1'b0;
    case (state_q)
      HIGH: begin
        if (tick) begin
          unit_d = unit_inc[CNT_W-1:0];
          if (unit_inc == {1'b0, th_q}) begin
            state_d = (unit_inc >= {1'b0, ts_q}) ? IDLE : LOW;
          end
        end
      end
      LOW: begin
        if (tick) unit_d = unit_inc[CNT_W-1:0];
        if (end_bit) state_d = IDLE;
      end
      LATCH: begin
        if (tick) begin
          rst_cnt_d = rst_inc[RST_W-1:0];
          if (rst_inc >= (RST_W + 1)'(RST_UNITS)) begin
            state_d   = IDLE;
            rst_cnt_d = '0;
            done_d    = 1'b1;
          end
        end
      end
      default: ;
    endcase
    if (bit_acc) begin
      th_d    = sel_th;
      ts_d    = sel_ts;
      unit_d  = '0;
      state_d = (sel_th == '0) ? LOW : HIGH;
    end else if (lat_acc) begin
      rst_cnt_d = '0;
      state_d   = LATCH;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      unit_q    <= '0;
      th_q      <= '0;
      ts_q      <= '0;
      rst_cnt_q <= '0;
      code_q    <= IDLE_LVL;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      unit_q    <= unit_d;
      th_q      <= th_d;
      ts_q      <= ts_d;
      rst_cnt_q <= rst_cnt_d;
      code_q    <= (state_d == HIGH) ? ~IDLE_LVL : IDLE_LVL;
      done_q    <= done_d;
    end
  end

  assign bus.bit_rdy_o  = rdy;
  assign bus.rst_done_o = done_q;
  assign bit_code_o     = code_q;
  assign state_o        = state_q;

endmodule

// File: tb/tb_ws281x_wave_gen.sv
// Scoreboard bench for ws281x_wave_gen: per-clock expected code/ready/done levels.
module tb_ws281x_wave_gen;

  localparam int TD   = 2;
  localparam int RSTU = 4;
`ifdef WS281X_WAVE_INV_EN
  localparam logic IDLE_LVL = 1'b1;
`else
  localparam logic IDLE_LVL = 1'b0;
`endif
  localparam logic HI_LVL = ~IDLE_LVL;

  logic clk;
  logic rst_i;
  logic code;
  ws281x_pkg::wave_state_t state;

  ws281x_wave_gen_if #(.CNT_W(8)) bus ();

  ws281x_wave_gen #(
    .TICK_DIV  (TD),
    .CNT_W     (8),
    .RST_UNITS (RSTU),
    .RST_W     (16)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .bus        (bus),
    .bit_code_o (code),
    .state_o    (state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard: one entry per clock {code, rdy, done}
  logic [2:0] exp_q[$];
  logic [2:0] mon_e;
  logic       mon_en;
  int         n_chk;
  int         n_pass;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: a bit is th*TD clocks high then the rest of max(ts,1) units low.
  function automatic void push_bit(input logic [7:0] th, input logic [7:0] ts_raw);
    int th_u, ts_u, lo;
    th_u = int'(th);
    ts_u = (int'(ts_raw) < th_u) ? th_u : int'(ts_raw);
    if (ts_u == 0) ts_u = 1;
    for (int i = 0; i < th_u * TD; i++) exp_q.push_back({HI_LVL, 1'b0, 1'b0});
    if (ts_u > th_u) begin
      lo = (ts_u - th_u) * TD;
      for (int i = 0; i < lo - 1; i++) exp_q.push_back({IDLE_LVL, 1'b0, 1'b0});
      exp_q.push_back({IDLE_LVL, 1'b1, 1'b0});
    end
  endfunction

  function automatic void push_latch();
    for (int i = 0; i < RSTU * TD; i++) exp_q.push_back({IDLE_LVL, 1'b0, 1'b0});
    exp_q.push_back({IDLE_LVL, 1'b1, 1'b1});
  endfunction

  // monitor
  always @(posedge clk) begin
    #1;
    if (mon_en) begin
      if (exp_q.size() > 0) mon_e = exp_q.pop_front();
      else mon_e = {IDLE_LVL, 1'b1, 1'b0};
      check("bit_code", 32'(code), 32'(mon_e[2]));
      check("bit_rdy", 32'(bus.bit_rdy_o), 32'(mon_e[1]));
      check("rst_done", 32'(bus.rst_done_o), 32'(mon_e[0]));
    end
  end

  // driver: called at a negedge, returns at the negedge after the accept
  task automatic send(input bit lat, input bit both, input bit d,
                      input logic [7:0] a0h, input logic [7:0] a0s,
                      input logic [7:0] a1h, input logic [7:0] a1s);
    int waited;
    bus.bit_vld_i  = !lat || both;
    bus.rst_req_i  = lat || both;
    bus.bit_data_i = d;
    bus.t0h_cnt_i  = a0h;
    bus.t0s_cnt_i  = a0s;
    bus.t1h_cnt_i  = a1h;
    bus.t1s_cnt_i  = a1s;
    waited = 0;
    while (!bus.bit_rdy_o && waited < 2000) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.bit_rdy_o) begin
      check("accept_wait", 32'(bus.bit_rdy_o), 32'd1);
      bus.bit_vld_i = 1'b0;
      bus.rst_req_i = 1'b0;
      return;
    end
    if (bus.bit_vld_i) push_bit(d ? a1h : a0h, d ? a1s : a0s);
    else push_latch();
    @(negedge clk);
    bus.bit_vld_i = 1'b0;
    bus.rst_req_i = 1'b0;
    bus.bit_data_i = 1'($urandom_range(0, 1));
    bus.t0h_cnt_i = 8'($urandom);
    bus.t0s_cnt_i = 8'($urandom);
    bus.t1h_cnt_i = 8'($urandom);
    bus.t1s_cnt_i = 8'($urandom);
  endtask

  function automatic logic [7:0] rnd_cnt();
    if ($urandom_range(0, 3) == 0) return 8'($urandom_range(0, 255));
    return 8'($urandom_range(0, 12));
  endfunction

  initial begin
    n_chk = 0;
    n_pass = 0;
    mon_en = 1'b0;
    rst_i = 1'b1;
    bus.bit_vld_i = 1'b0;
    bus.rst_req_i = 1'b0;
    bus.bit_data_i = 1'b0;
    bus.t0h_cnt_i = 8'd0;
    bus.t0s_cnt_i = 8'd0;
    bus.t1h_cnt_i = 8'd0;
    bus.t1s_cnt_i = 8'd0;
    repeat (3) @(negedge clk);
    check("reset_code", 32'(code), 32'(IDLE_LVL));
    check("reset_rdy", 32'(bus.bit_rdy_o), 32'd1);
    check("reset_done", 32'(bus.rst_done_o), 32'd0);
    check("reset_state", 32'(state), 32'(ws281x_pkg::IDLE));
    rst_i = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);

    // 0-code with default timings; then 1-code followed back-to-back by a 0-code
    send(1'b0, 1'b0, 1'b0, 8'h01, 8'h80, 8'hfe, 8'hff);
    repeat (3) @(negedge clk);
    send(1'b0, 1'b0, 1'b1, 8'h01, 8'h80, 8'hfe, 8'hff);
    send(1'b0, 1'b0, 1'b0, 8'h01, 8'h80, 8'hfe, 8'hff);
    // period shorter than high time, zero high time, fully degenerate bit
    send(1'b0, 1'b0, 1'b0, 8'h05, 8'h03, 8'h00, 8'h00);
    send(1'b0, 1'b0, 1'b1, 8'h05, 8'h03, 8'h00, 8'h07);
    send(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h09, 8'h09);
    send(1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'h02, 8'h02);
    repeat (2) @(negedge clk);
    // latch alone, latch request with a bit (bit wins), latch right after a bit
    send(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
    send(1'b1, 1'b1, 1'b1, 8'h02, 8'h04, 8'h03, 8'h06);
    send(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
    send(1'b0, 1'b0, 1'b0, 8'h01, 8'h03, 8'h00, 8'h00);

    // synchronous reset during HIGH
    send(1'b0, 1'b0, 1'b1, 8'h01, 8'h02, 8'd200, 8'd255);
    repeat (10) @(negedge clk);
    rst_i = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check("midrst_state", 32'(state), 32'(ws281x_pkg::IDLE));
    check("midrst_code", 32'(code), 32'(IDLE_LVL));
    rst_i = 1'b0;
    @(negedge clk);

    // randomized traffic
    for (int n = 0; n < 40; n++) begin
      send(1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 9) == 0),
           1'($urandom_range(0, 1)), rnd_cnt(), rnd_cnt(), rnd_cnt(), rnd_cnt());
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    begin
      int w;
      w = 0;
      while (exp_q.size() > 0 && w < 3000) begin
        @(negedge clk);
        w++;
      end
    end
    check("drain", 32'(exp_q.size()), 32'd0);
    repeat (4) @(negedge clk);
    mon_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
